// File: rtl/experiment_top_level.sv
// Optical Ising-machine experiment top: GPIO-loaded config/LUTs, DMA-fed FIFOs, DAC/ADC sequencer.
// Define PROGRAM_LOOP_EN to re-queue every issued instruction/beta pair so the program repeats.

module experiment_fifo #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] head,
  output logic        empty,
  output logic        full
);
  logic [15:0]   mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(2**AW));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO may still take a re-queued word.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module experiment_top_level #(
  parameter int INSTR_FIFO_DEPTH = 8,
  parameter int WAVE_POS         = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  gpio_in,
  output logic [31:0]  gpio_out_bus,
  output logic [255:0] m0_axis_tdata, m1_axis_tdata, m2_axis_tdata,
  output logic [255:0] m3_axis_tdata, m4_axis_tdata, m5_axis_tdata,
  output logic [255:0] m6_axis_tdata, m7_axis_tdata, m8_axis_tdata,
  output logic         m0_axis_tvalid, m1_axis_tvalid, m2_axis_tvalid,
  output logic         m3_axis_tvalid, m4_axis_tvalid, m5_axis_tvalid,
  output logic         m6_axis_tvalid, m7_axis_tvalid, m8_axis_tvalid,
  input  logic         m0_axis_tready, m1_axis_tready, m2_axis_tready,
  input  logic         m3_axis_tready, m4_axis_tready, m5_axis_tready,
  input  logic         m6_axis_tready, m7_axis_tready, m8_axis_tready,
  input  logic [127:0] s0_axis_tdata,
  input  logic         s0_axis_tvalid,
  output logic         s0_axis_tready,
  input  logic [127:0] s1_axis_tdata,
  input  logic         s1_axis_tvalid,
  output logic         s1_axis_tready,
  input  logic [15:0]  s2_axis_tdata,
  input  logic         s2_axis_tvalid,
  output logic         s2_axis_tready
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t      state;
  logic [2:0]  wclk_sync;
  logic        wr_stb;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] instr_b_sel_reg, run_reg, adc_wait_reg;
  logic [15:0] const_reg    [5];
  logic [15:0] lut_addr_reg [6];
  logic [15:0] lut_data_reg [6];
  logic [5:0]  lut_wcnt, lut_commit;
  logic        is_lut, is_const;
  logic [2:0]  lut_sel;
  logic [15:0] commit_word;
  logic [15:0] lut_a [256], lut_anl [256], lut_b [256], lut_c [256];
  logic [7:0]  lut_mac [256], lut_nl [256];
  logic [15:0] instr_word, beta_word, i_head, b_head, i_push_data;
  logic        i_empty, i_full, b_empty, b_full, i_push, b_push, pop, dma_push, sel_b;
  logic [7:0]  wait_cnt, mac_res, nl_res, exec_cnt, status;
  logic        mac_got, nl_got, done;
  logic [255:0] dac_q [9];

  function automatic logic [255:0] lane_word(input logic [15:0] v);
    lane_word = '0;
    lane_word[16*WAVE_POS +: 16] = v;
  endfunction

  assign wr_stb   = wclk_sync[1] && !wclk_sync[2];
  assign wr_addr  = gpio_in[15:0];
  assign wr_data  = gpio_in[23:16];
  assign is_lut   = (wr_addr[15:4] == 12'h001) && (wr_addr[3:0] < 4'hC);
  assign is_const = (wr_addr[15:3] == 13'h0004) && (wr_addr[2:0] < 3'd5);
  assign lut_sel  = is_lut ? wr_addr[3:1] : 3'd0;
  assign commit_word = {lut_data_reg[lut_sel][7:0], wr_data};

  // Every second write to a LUT data address commits the assembled word.
  always_comb begin
    lut_commit = '0;
    if (wr_stb && is_lut && wr_addr[0] && lut_wcnt[lut_sel]) lut_commit[lut_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wclk_sync       <= '0;
      instr_b_sel_reg <= '0;
      run_reg         <= '0;
      adc_wait_reg    <= '0;
      lut_wcnt        <= '0;
      for (int k = 0; k < 5; k++) const_reg[k] <= '0;
      for (int k = 0; k < 6; k++) begin
        lut_addr_reg[k] <= '0;
        lut_data_reg[k] <= '0;
      end
    end else begin
      wclk_sync <= {wclk_sync[1:0], gpio_in[24]};
      if (wr_stb) begin
        if (wr_addr == 16'h0001) instr_b_sel_reg <= {instr_b_sel_reg[7:0], wr_data};
        if (wr_addr == 16'h0002) run_reg         <= {run_reg[7:0], wr_data};
        if (wr_addr == 16'h0003) adc_wait_reg    <= {adc_wait_reg[7:0], wr_data};
        if (is_const) const_reg[wr_addr[2:0]] <= {const_reg[wr_addr[2:0]][7:0], wr_data};
        if (is_lut && !wr_addr[0]) lut_addr_reg[lut_sel] <= {lut_addr_reg[lut_sel][7:0], wr_data};
        if (is_lut && wr_addr[0]) begin
          lut_data_reg[lut_sel] <= {lut_data_reg[lut_sel][7:0], wr_data};
          lut_wcnt[lut_sel]     <= !lut_wcnt[lut_sel];
        end
      end
    end
  end

  // LUTs behave as RAM: contents survive reset and are only changed by commits.
  always_ff @(posedge clk) begin
    if (lut_commit[0]) lut_a  [lut_addr_reg[0][7:0]]  <= commit_word;
    if (lut_commit[1]) lut_anl[lut_addr_reg[1][7:0]]  <= commit_word;
    if (lut_commit[2]) lut_b  [lut_addr_reg[2][7:0]]  <= commit_word;
    if (lut_commit[3]) lut_c  [lut_addr_reg[3][7:0]]  <= commit_word;
    if (lut_commit[4]) lut_mac[lut_addr_reg[4][15:8]] <= commit_word[7:0];
    if (lut_commit[5]) lut_nl [lut_addr_reg[5][15:8]] <= commit_word[7:0];
  end

  assign sel_b    = instr_b_sel_reg[0];
  assign pop      = (state == S_IDLE) && run_reg[0] && !i_empty && !b_empty;
  assign dma_push = s2_axis_tvalid && s2_axis_tready;

`ifdef PROGRAM_LOOP_EN
  // DMA is held off during a pop so the re-queue owns the FIFO write port.
  assign s2_axis_tready = !(sel_b ? b_full : i_full) && !pop;
  assign i_push      = (dma_push && !sel_b) || pop;
  assign b_push      = (dma_push && sel_b) || pop;
  assign i_push_data = pop ? i_head : s2_axis_tdata;
  assign done        = 1'b0;
`else
  assign s2_axis_tready = !(sel_b ? b_full : i_full);
  assign i_push      = dma_push && !sel_b;
  assign b_push      = dma_push && sel_b;
  assign i_push_data = s2_axis_tdata;
  assign done        = run_reg[0] && i_empty && (state == S_IDLE);
`endif

  experiment_fifo #(.AW(INSTR_FIFO_DEPTH)) u_instr_fifo (
    .clk(clk), .rst(rst), .push(i_push), .push_data(i_push_data), .pop(pop),
    .head(i_head), .empty(i_empty), .full(i_full)
  );

  experiment_fifo #(.AW(INSTR_FIFO_DEPTH)) u_beta_fifo (
    .clk(clk), .rst(rst), .push(b_push), .push_data(pop ? b_head : s2_axis_tdata), .pop(pop),
    .head(b_head), .empty(b_empty), .full(b_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      instr_word <= '0;
      beta_word  <= '0;
      wait_cnt   <= '0;
      mac_res    <= '0;
      nl_res     <= '0;
      exec_cnt   <= '0;
      mac_got    <= 1'b0;
      nl_got     <= 1'b0;
      for (int k = 0; k < 9; k++) dac_q[k] <= '0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          instr_word <= i_head;
          beta_word  <= b_head;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          dac_q[0] <= lane_word(lut_a[instr_word[15:8]]);
          dac_q[1] <= lane_word(lut_b[beta_word[7:0]]);
          dac_q[2] <= lane_word(lut_c[instr_word[7:0]]);
          dac_q[3] <= lane_word(lut_anl[mac_res]);
          for (int k = 0; k < 5; k++) dac_q[4+k] <= lane_word(const_reg[k]);
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == adc_wait_reg[7:0]) begin
            mac_got <= 1'b0;
            nl_got  <= 1'b0;
            state   <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_CAPTURE: begin
          // Each ADC stream is sampled once, on its own first valid beat.
          if (s0_axis_tvalid && !mac_got) begin
            mac_res <= lut_mac[s0_axis_tdata[16*WAVE_POS+8 +: 8]];
            mac_got <= 1'b1;
          end
          if (s1_axis_tvalid && !nl_got) begin
            nl_res <= lut_nl[s1_axis_tdata[16*WAVE_POS+8 +: 8]];
            nl_got <= 1'b1;
          end
          if ((mac_got || s0_axis_tvalid) && (nl_got || s1_axis_tvalid)) begin
            exec_cnt <= exec_cnt + 8'd1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign status         = {3'b000, i_full, b_empty, i_empty, done, state != S_IDLE};
  assign gpio_out_bus   = {status, nl_res, mac_res, exec_cnt};
  assign s0_axis_tready = 1'b1;
  assign s1_axis_tready = 1'b1;

  assign m0_axis_tdata = dac_q[0];
  assign m1_axis_tdata = dac_q[1];
  assign m2_axis_tdata = dac_q[2];
  assign m3_axis_tdata = dac_q[3];
  assign m4_axis_tdata = dac_q[4];
  assign m5_axis_tdata = dac_q[5];
  assign m6_axis_tdata = dac_q[6];
  assign m7_axis_tdata = dac_q[7];
  assign m8_axis_tdata = dac_q[8];
  assign {m0_axis_tvalid, m1_axis_tvalid, m2_axis_tvalid, m3_axis_tvalid, m4_axis_tvalid,
          m5_axis_tvalid, m6_axis_tvalid, m7_axis_tvalid, m8_axis_tvalid} = {9{!rst}};

  logic unused_bits;
  always_comb begin
    unused_bits = ^{gpio_in[31:25], m0_axis_tready, m1_axis_tready, m2_axis_tready,
                    m3_axis_tready, m4_axis_tready, m5_axis_tready, m6_axis_tready,
                    m7_axis_tready, m8_axis_tready, s0_axis_tdata, s1_axis_tdata,
                    instr_b_sel_reg, run_reg, adc_wait_reg};
    for (int k = 0; k < 6; k++) unused_bits = unused_bits ^ (^{lut_addr_reg[k], lut_data_reg[k]});
  end
endmodule

// File: tb/tb_experiment_top_level.sv
// Directed self-checking bench for experiment_top_level (default build; PROGRAM_LOOP_EN selects the loop scenario).

module tb_experiment_top_level;
  logic         clk = 1'b0;
  logic         rst;
  logic         w_clk;
  logic [7:0]   g_data;
  logic [15:0]  g_addr;
  logic [31:0]  gpio_in, gpio_out_bus;
  logic [255:0] m_tdata [9];
  logic [8:0]   m_tvalid;
  logic [127:0] s0_tdata, s1_tdata;
  logic         s0_tvalid, s1_tvalid, s0_tready, s1_tready;
  logic [15:0]  s2_tdata;
  logic         s2_tvalid, s2_tready;
  int           assert_cnt = 0;
  int           fail_cnt = 0;
  int           accepted;

  always #5 clk = ~clk;
  assign gpio_in = {7'd0, w_clk, g_data, g_addr};

  experiment_top_level dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out_bus(gpio_out_bus),
    .m0_axis_tdata(m_tdata[0]), .m1_axis_tdata(m_tdata[1]), .m2_axis_tdata(m_tdata[2]),
    .m3_axis_tdata(m_tdata[3]), .m4_axis_tdata(m_tdata[4]), .m5_axis_tdata(m_tdata[5]),
    .m6_axis_tdata(m_tdata[6]), .m7_axis_tdata(m_tdata[7]), .m8_axis_tdata(m_tdata[8]),
    .m0_axis_tvalid(m_tvalid[0]), .m1_axis_tvalid(m_tvalid[1]), .m2_axis_tvalid(m_tvalid[2]),
    .m3_axis_tvalid(m_tvalid[3]), .m4_axis_tvalid(m_tvalid[4]), .m5_axis_tvalid(m_tvalid[5]),
    .m6_axis_tvalid(m_tvalid[6]), .m7_axis_tvalid(m_tvalid[7]), .m8_axis_tvalid(m_tvalid[8]),
    .m0_axis_tready(1'b0), .m1_axis_tready(1'b0), .m2_axis_tready(1'b0),
    .m3_axis_tready(1'b0), .m4_axis_tready(1'b0), .m5_axis_tready(1'b0),
    .m6_axis_tready(1'b0), .m7_axis_tready(1'b0), .m8_axis_tready(1'b0),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .s2_axis_tdata(s2_tdata), .s2_axis_tvalid(s2_tvalid), .s2_axis_tready(s2_tready)
  );

  function automatic logic [255:0] lane4(input logic [15:0] v);
    lane4 = {176'd0, v, 64'd0};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One GPIO write: addr/data settle first, then a held w_clk pulse.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
    g_addr = addr;
    g_data = data;
    repeat (2) @(posedge clk);
    #1 w_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 w_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic gpioPair(input logic [15:0] addr, input logic [7:0] d1, input logic [7:0] d2);
    applyStimulus(addr, d1);
    applyStimulus(addr, d2);
  endtask

  task automatic dmaPush(input logic b_sel, input logic [15:0] word);
    applyStimulus(16'h0001, {7'd0, b_sel});
    s2_tdata  = word;
    s2_tvalid = 1'b1;
    @(posedge clk);
    #1 s2_tvalid = 1'b0;
  endtask

  task automatic waitExec(input logic [7:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (gpio_out_bus[7:0] !== target && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput(tag, 256'(gpio_out_bus[7:0]), 256'(target));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    w_clk     = 1'b0;
    g_data    = '0;
    g_addr    = '0;
    s2_tdata  = '0;
    s2_tvalid = 1'b0;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    s0_tdata  = {48'hEEEE_EEEE_EEEE, 16'h7F00, 64'hEEEE_EEEE_EEEE_EEEE};
    s1_tdata  = {48'hDDDD_DDDD_DDDD, 16'h3300, 64'hDDDD_DDDD_DDDD_DDDD};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 256'(m_tvalid), 256'(9'h000));
    checkOutput("rst_m0", m_tdata[0], 256'd0);
    checkOutput("rst_gpio_out", 256'(gpio_out_bus), 256'(32'h0C00_0000));
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("tvalid_after_rst", 256'(m_tvalid), 256'(9'h1FF));
    checkOutput("adc_tready", 256'({s0_tready, s1_tready, s2_tready}), 256'(3'b111));

    $display("[TB] Filling instruction FIFO with 300 offered words");
    accepted  = 0;
    s2_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s2_tdata = 16'(i);
      @(negedge clk);
      if (s2_tready) accepted++;
      @(posedge clk);
      #1;
    end
    s2_tvalid = 1'b0;
    checkOutput("fifo_accepted", 256'(accepted), 256'd256);
    checkOutput("fifo_full_tready", 256'(s2_tready), 256'd0);
    checkOutput("fifo_full_status", 256'(gpio_out_bus[31:24]), 256'(8'h18));

    doReset();
    @(posedge clk);
    #1 checkOutput("fifo_cleared_status", 256'(gpio_out_bus[31:24]), 256'(8'h0C));

    $display("[TB] Programming LUTs and constants");
    gpioPair(16'h0010, 8'h00, 8'h05);
    gpioPair(16'h0011, 8'h12, 8'h34);
    applyStimulus(16'h0011, 8'h99);
    gpioPair(16'h0018, 8'h7F, 8'h00);
    gpioPair(16'h0019, 8'h00, 8'h81);
    gpioPair(16'h001A, 8'h33, 8'h00);
    gpioPair(16'h001B, 8'h00, 8'h5A);
    gpioPair(16'h0014, 8'h00, 8'h02);
    gpioPair(16'h0015, 8'h0B, 8'h0B);
    gpioPair(16'h0016, 8'h00, 8'h03);
    gpioPair(16'h0017, 8'h0C, 8'h0C);
    gpioPair(16'h0012, 8'h00, 8'h00);
    gpioPair(16'h0013, 8'h0A, 8'hAA);
    applyStimulus(16'h0012, 8'h81);
    gpioPair(16'h0013, 8'h0B, 8'hBB);
    gpioPair(16'h0020, 8'h11, 8'h22);
    gpioPair(16'h0021, 8'h33, 8'h44);
    gpioPair(16'h0022, 8'h55, 8'h66);
    gpioPair(16'h0023, 8'h77, 8'h88);
    gpioPair(16'h0024, 8'h99, 8'hAA);
    applyStimulus(16'h00FF, 8'h55);

`ifndef PROGRAM_LOOP_EN
    dmaPush(1'b0, 16'h0503);
    dmaPush(1'b1, 16'h0002);
    checkOutput("loaded_status", 256'(gpio_out_bus[31:24]), 256'(8'h00));
    applyStimulus(16'h0002, 8'h01);
    waitExec(8'd1, 200, "exec_cnt_first");
    checkOutput("m0_alpha", m_tdata[0], lane4(16'h1234));
    checkOutput("m1_beta", m_tdata[1], lane4(16'h0B0B));
    checkOutput("m2_gamma", m_tdata[2], lane4(16'h0C0C));
    checkOutput("m3_alpha_nl", m_tdata[3], lane4(16'h0AAA));
    checkOutput("m4_phi_lo", m_tdata[4], lane4(16'h1122));
    checkOutput("m5_phi", m_tdata[5], lane4(16'h3344));
    checkOutput("m6_a", m_tdata[6], lane4(16'h5566));
    checkOutput("m7_a_nl", m_tdata[7], lane4(16'h7788));
    checkOutput("m8_phi_nl", m_tdata[8], lane4(16'h99AA));
    checkOutput("gpio_out_done", 256'(gpio_out_bus), 256'(32'h0E5A_8101));

    dmaPush(1'b0, 16'h0503);
    checkOutput("beta_empty_stays_idle", 256'(gpio_out_bus[31:24]), 256'(8'h08));
    dmaPush(1'b1, 16'h0002);
    waitExec(8'd2, 200, "exec_cnt_second");
    checkOutput("m3_alpha_nl_mac", m_tdata[3], lane4(16'h0BBB));
    checkOutput("gpio_out_second", 256'(gpio_out_bus), 256'(32'h0E5A_8102));

    $display("[TB] Reset during WAIT");
    applyStimulus(16'h0003, 8'h3C);
    dmaPush(1'b0, 16'h0503);
    dmaPush(1'b1, 16'h0002);
    repeat (5) @(posedge clk);
    #1 checkOutput("busy_in_wait", 256'(gpio_out_bus[24]), 256'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wait_rst_m0", m_tdata[0], 256'd0);
    checkOutput("wait_rst_m8", m_tdata[8], 256'd0);
    checkOutput("wait_rst_gpio_out", 256'(gpio_out_bus), 256'(32'h0C00_0000));
    checkOutput("wait_rst_tvalid", 256'(m_tvalid), 256'(9'h000));
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_idle", 256'(gpio_out_bus), 256'(32'h0C00_0000));
    checkOutput("post_rst_tvalid", 256'(m_tvalid), 256'(9'h1FF));
`else
    $display("[TB] Looping two-word program");
    dmaPush(1'b0, 16'h0503);
    dmaPush(1'b0, 16'h0503);
    dmaPush(1'b1, 16'h0002);
    dmaPush(1'b1, 16'h0002);
    applyStimulus(16'h0002, 8'h01);
    waitExec(8'd4, 400, "loop_exec_cnt");
    checkOutput("loop_not_done", 256'(gpio_out_bus[26:25]), 256'(2'b00));
    checkOutput("loop_m0", m_tdata[0], lane4(16'h1234));
    applyStimulus(16'h0002, 8'h00);
    repeat (20) @(posedge clk);
    #1 checkOutput("loop_stopped_status", 256'(gpio_out_bus[31:24]), 256'(8'h00));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
